// File: rtl/proc_pkg.sv
// Shared types and parameter defaults for the round-robin processing engine.
package proc_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} proc_state_e;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 8;
  localparam int LAT_DEF = 3;
endpackage

// File: rtl/proc_rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`, wrapping mod NCH.
module rr_arbiter #(
  parameter int NCH = proc_pkg::NCH_DEF,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  input  logic           en,
  output logic [NCH-1:0] win,
  output logic [CW-1:0]  win_idx
);
  logic found;
  int   j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 1; i <= NCH; i++) begin
      j = (int'(last) + i) % NCH;
      if (en && !found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = CW'(j);
      end
    end
  end
endmodule

// File: rtl/proc_rr.sv
// Multi-channel request/grant/done engine: round-robin arbiter feeding one
// shared slot that returns operand+1 after LAT cycles.
module proc_rr
  import proc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int LAT = LAT_DEF,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    gnt,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     done_ch,
  output logic [DW-1:0]     done_data
);
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  proc_state_e                state;
  logic [CNTW-1:0]            cnt;
  logic [CW-1:0]              last;
  logic [DW-1:0]              data_q;
  logic [NCH-1:0][DW-1:0]     req_v;
  logic [NCH-1:0]             win;
  logic [CW-1:0]              win_idx;

  assign req_v = req_data;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req),
    .last    (last),
    .en      (state == IDLE),
    .win     (win),
    .win_idx (win_idx)
  );

  // `last` doubles as the in-flight channel id: it only moves on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= CW'(NCH - 1);
      data_q    <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_ch   <= '0;
      done_data <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE: if (|win) begin
          gnt    <= win;
          last   <= win_idx;
          data_q <= req_v[win_idx];
          cnt    <= CNTW'(LAT - 1);
          busy   <= 1'b1;
          state  <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          state     <= DONE;
          done      <= 1'b1;
          done_ch   <= last;
          done_data <= data_q + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_rr.sv
// Directed bench for proc_rr (NCH=4, DW=8, LAT=3) with immediate assertions.
module tb_proc_rr;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][7:0] rd;
  logic [3:0]      gnt;
  logic            busy, done;
  logic [1:0]      done_ch;
  logic [7:0]      done_data;

  int tests  = 0;
  int failed = 0;

  proc_rr #(.NCH(4), .DW(8), .LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (rd),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_ch   (done_ch),
    .done_data (done_data)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] dat [4];
    logic [7:0] e8;
    int         e;
    dat[0] = 8'h10; dat[1] = 8'hFF; dat[2] = 8'h41; dat[3] = 8'h7E;
    for (int i = 0; i < 4; i++) rd[i] = dat[i];

    // reset held 3 edges with all channels requesting
    rst_n = 1'b0; req = 4'hF;
    tick(3);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_ch", done_ch, 0);
    chk("rst_done_data", done_data, 0);

    // first edge out of reset grants ch0
    rst_n = 1'b1;
    tick(1);
    chk("first_gnt", gnt, 4'b0001);
    chk("first_busy", busy, 1);
    req = 4'h0;
    tick(2);
    chk("first_nodone", done, 0);
    chk("first_gnt_pulse", gnt, 0);
    tick(1);
    chk("first_done", done, 1);
    chk("first_done_ch", done_ch, 0);
    chk("first_done_data", done_data, 8'h11);
    chk("first_busy_at_done", busy, 1);
    tick(1);
    chk("first_idle_busy", busy, 0);
    chk("first_idle_done", done, 0);

    // single request on ch2
    req = 4'b0100;
    tick(1);
    chk("single_gnt", gnt, 4'b0100);
    req = 4'h0;
    tick(3);
    chk("single_done", done, 1);
    chk("single_done_ch", done_ch, 2);
    chk("single_done_data", done_data, 8'h42);
    tick(1);
    chk("single_hold_ch", done_ch, 2);
    chk("single_busy_fall", busy, 0);

    // wrap: ch1 operand FF
    req = 4'b0010;
    tick(1);
    chk("wrap_gnt", gnt, 4'b0010);
    req = 4'h0;
    tick(3);
    chk("wrap_done", done, 1);
    chk("wrap_done_ch", done_ch, 1);
    chk("wrap_done_data", done_data, 8'h00);
    tick(1);

    // reset mid-BUSY drops the transaction
    req = 4'b1000;
    tick(1);
    chk("midrst_gnt", gnt, 4'b1000);
    req = 4'h0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(1);
      chk("midrst_no_done", done, 0);
    end

    // fairness: all channels held, pointer back at 3 so ch0 leads
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      e  = g % 4;
      e8 = dat[e] + 8'd1;
      tick(1);
      chk("fair_gnt", gnt, 32'(1 << e));
      for (int t = 1; t <= 4; t++) begin
        tick(1);
        chk("fair_gap_gnt", gnt, 0);
        if (t == 3) begin
          chk("fair_done", done, 1);
          chk("fair_done_ch", done_ch, e);
          chk("fair_done_data", done_data, e8);
        end else begin
          chk("fair_nodone", done, 0);
        end
      end
    end
    req = 4'h0;

    // ch0 holds through BUSY, ch1 only pulses while busy
    req = 4'b0001;
    tick(1);
    chk("wd_gnt0", gnt, 4'b0001);
    req = 4'b0011;
    tick(2);
    req = 4'b0001;
    tick(1);
    chk("wd_done", done, 1);
    chk("wd_done_data", done_data, 8'h11);
    tick(1);
    chk("wd_idle_gnt", gnt, 0);
    chk("wd_idle_busy", busy, 0);
    tick(1);
    chk("wd_regrant_ch0", gnt, 4'b0001);
    req = 4'h0;
    tick(5);
    chk("wd_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/proc_rr.md
# proc_rr

Parametrised successor to the single-channel `proc` handshake DUT used by the SVA examples. Multi-channel request/grant/done engine: a round-robin arbiter over `NCH` requesters feeds one shared processing slot. The slot latches the winner's data, holds it for `LAT` cycles, and then returns a one-cycle `done` pulse carrying the result and channel id. The block sits in the chapter bench as the DUT for multi-channel handshake, fairness and latency assertions.

## Interface
- `NCH`, 4, number of requesting channels (2..16)
- `DW`, 8, data width per channel
- `LAT`, 3, processing latency in cycles (≥1)
- `CW`, $clog2(NCH), channel-id width (derived, not overridden)

- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  NCH  per-channel request level
- `req_data`  in  NCH×DW  per-channel operand (packed, channel i at [i*DW +: DW])
- `gnt`  out  NCH  one-hot grant pulse, one cycle
- `busy`  out  1  slot occupied (BUSY or DONE state)
- `done`  out  1  result-valid pulse, one cycle
- `done_ch`  out  CW  channel id of the completing transaction
- `done_data`  out  DW  result = latched operand + 1, modulo 2^DW

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if `req`≠0 at an edge, the arbiter picks winner w. Grant `gnt[w]`=1, latch `req_data[w]` and w, load `cnt`=LAT-1, go to BUSY. Otherwise stay in IDLE with `gnt`=0.
- BUSY: each edge, if `cnt`==0 go to DONE, else decrement `cnt`. `req` is ignored.
- DONE: `done`=1 and `done_ch`/`done_data` valid for exactly this cycle. Next edge goes to IDLE unconditionally.
- Round-robin: pointer `last` holds the most recently granted channel. Search order is `last`+1, `last`+2, … wrapping mod NCH. `last` updates only on a grant.
- Requesters hold `req` until they see `gnt`. Dropping `req` before grant is a legal withdrawal. `req` still high after `gnt` is a new request.
- `done_data` wraps: 8'hFF → 8'h00.
- `done_ch`/`done_data` hold their last values outside `done`. Checks must qualify them with `done`.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `busy`=0, `done`=0, `done_ch`=0, `done_data`=0, state=IDLE, `cnt`=0, `last`=NCH-1 (channel 0 has first priority).
- Grant decided at edge k: `gnt` high in cycle k..k+1 and `busy` rises at edge k. `done` is high after edge k+LAT, and `busy` falls at edge k+LAT+1.
- Next grant is possible at edge k+LAT+2 at the earliest. Sustained throughput is one transaction per LAT+2 cycles.
- `rst_n` low at any edge returns everything to reset values at that edge, including mid-BUSY. An in-flight transaction is dropped with no `done`.
- The first edge with `rst_n` high may grant.
- Simultaneous requests: exactly one grant, chosen by the pointer. `gnt` is always one-hot or zero.
- `busy` is never 0 while `done`=1.

## Structure
- `proc_pkg`: `typedef enum logic [1:0] {IDLE, BUSY, DONE} proc_state_e;` and shared parameter defaults.
- Sub-module `rr_arbiter #(NCH)`:
  - inputs `req`, `last`, `en`; outputs one-hot `win` and its index.
  - Combinational only; the pointer register lives in `proc_rr`.
- Top level holds the FSM, counter, latches and output registers.

## Test plan
- Reset check: hold `rst_n`=0 for 3 edges with `req`=4'hF → `gnt`=0, `busy`=0, `done`=0. First edge after release grants ch0.
- Single request: ch2 `req` with data 8'h41 at edge k → `gnt`=4'b0100 at k, `done`=1 after k+3 with `done_ch`=2 and `done_data`=8'h42.
- Fairness: `req`=4'hF held continuously → grant order 0,1,2,3,0, spaced 5 edges apart (LAT=3). Each grant is followed by exactly one `done`.
- Wrap: ch1 data 8'hFF → `done_data`=8'h00.
- Reset mid-BUSY: grant ch3, drop `rst_n` one edge later → no `done`. After release `last`=3 again and ch0 wins.
- Withdrawal and requests while busy: ch1 pulses `req` only during BUSY → never granted. ch0 holding through BUSY → granted at k+LAT+2.
